// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU.
package alu_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'b000;
    localparam opcode_t OP_SUB  = 3'b001;
    localparam opcode_t OP_AND  = 3'b010;
    localparam opcode_t OP_OR   = 3'b011;
    localparam opcode_t OP_XOR  = 3'b100;
    localparam opcode_t OP_ACC  = 3'b101;
    localparam opcode_t OP_CLR  = 3'b110;
    localparam opcode_t OP_PASS = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; saturating arithmetic is built when ALU_SAT_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    input  logic [N-1:0] acc,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         ovf,
    output logic         acc_we
);

    logic [N-1:0] lhs_s;
    logic [N-1:0] rhs_s;
    logic [N:0]   add_full_s;
    logic [N:0]   sub_full_s;
    logic         add_ovf_s;
    logic         sub_ovf_s;
    logic [N-1:0] raw_s;
    logic [N-1:0] sat_val_s;
    opcode_t      op_s;

    assign op_s = opcode_t'(op);

    // ACC adds in0 onto the accumulator, so acc takes the operand-A role there.
    always_comb begin
        lhs_s      = (op_s == OP_ACC) ? acc : a;
        rhs_s      = (op_s == OP_ACC) ? a : b;
        add_full_s = {1'b0, lhs_s} + {1'b0, rhs_s};
        sub_full_s = {1'b0, a} - {1'b0, b};
        add_ovf_s  = (lhs_s[N-1] == rhs_s[N-1]) && (add_full_s[N-1] != lhs_s[N-1]);
        sub_ovf_s  = (a[N-1] != b[N-1]) && (sub_full_s[N-1] != a[N-1]);
        // Overflow direction always follows the sign of operand A.
        sat_val_s  = lhs_s[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end

    // Opcode decode: raw result, flags and accumulator write enable.
    always_comb begin
        raw_s  = {N{1'b0}};
        carry  = 1'b0;
        ovf    = 1'b0;
        acc_we = 1'b0;
        case (op_s)
            OP_ADD: begin
                raw_s = add_full_s[N-1:0];
                carry = add_full_s[N];
                ovf   = add_ovf_s;
            end
            OP_SUB: begin
                raw_s = sub_full_s[N-1:0];
                carry = sub_full_s[N];
                ovf   = sub_ovf_s;
            end
            OP_AND:  raw_s = a & b;
            OP_OR:   raw_s = a | b;
            OP_XOR:  raw_s = a ^ b;
            OP_ACC: begin
                raw_s  = add_full_s[N-1:0];
                carry  = add_full_s[N];
                ovf    = add_ovf_s;
                acc_we = 1'b1;
            end
            OP_CLR: begin
                raw_s  = {N{1'b0}};
                acc_we = 1'b1;
            end
            OP_PASS: raw_s = a;
            default: raw_s = {N{1'b0}};
        endcase
    end

    // Final result; only ADD/SUB/ACC can raise ovf, so saturation touches nothing else.
    always_comb begin
`ifdef ALU_SAT_EN
        if (ovf) begin
            result = sat_val_s;
        end else begin
            result = raw_s;
        end
`else
        result = raw_s;
`endif
    end

endmodule

// File: rtl/alu_pipe_reg.sv
// Two-stage pipelined ALU with valid qualifier, flags and accumulator.
// Optional build macro ALU_SAT_EN selects saturating ADD/SUB/ACC in alu_core.
module alu_pipe_reg
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [2:0]   op,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         carry,
    output logic         zero,
    output logic         ovf
);

    logic         s1_valid_r;
    logic [2:0]   s1_op_r;
    logic [N-1:0] s1_a_r;
    logic [N-1:0] s1_b_r;
    logic [N-1:0] acc_r;

    logic [N-1:0] result_s;
    logic         carry_s;
    logic         ovf_s;
    logic         acc_we_s;

    // Stage 1: capture operands, opcode and valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_op_r    <= 3'b000;
            s1_a_r     <= {N{1'b0}};
            s1_b_r     <= {N{1'b0}};
        end else begin
            s1_valid_r <= in_valid;
            s1_op_r    <= op;
            s1_a_r     <= in0;
            s1_b_r     <= in1;
        end
    end

    alu_core #(.N(N)) u_core (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .op     (s1_op_r),
        .acc    (acc_r),
        .result (result_s),
        .carry  (carry_s),
        .ovf    (ovf_s),
        .acc_we (acc_we_s)
    );

    // Stage 2: register result and flags; bubbles hold everything but out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= {N{1'b0}};
            out_valid <= 1'b0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s1_valid_r) begin
            out       <= result_s;
            out_valid <= 1'b1;
            carry     <= carry_s;
            zero      <= (result_s == {N{1'b0}});
            ovf       <= ovf_s;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator; written in the same edge as out so back-to-back ACCs chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {N{1'b0}};
        end else if (s1_valid_r && acc_we_s) begin
            acc_r <= result_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: tb/tb_alu_pipe_reg.sv
// Scoreboard bench for alu_pipe_reg (N=4); expectations follow ALU_SAT_EN when defined.
module tb_alu_pipe_reg;

`ifdef ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] o;
        logic       c;
        logic       z;
        logic       v;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [2:0] op;
    logic [3:0] in0;
    logic [3:0] in1;
    logic [3:0] out;
    logic       out_valid;
    logic       carry;
    logic       zero;
    logic       ovf;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    alu_pipe_reg #(.N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .out       (out),
        .out_valid (out_valid),
        .carry     (carry),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got out=%b c=%b z=%b v=%b, expected no valid output",
                         out, carry, zero, ovf);
            end else begin
                mon_e = exp_q.pop_front();
                if ({out, carry, zero, ovf} !== mon_e) begin
                    fails++;
                    $display("FAIL result: got out=%b c=%b z=%b v=%b, expected out=%b c=%b z=%b v=%b",
                             out, carry, zero, ovf, mon_e.o, mon_e.c, mon_e.z, mon_e.v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic issue(input logic v, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b,
                         input bit push, input logic [3:0] eo, input logic ec, input logic ez,
                         input logic ev);
        @(negedge clk);
        in_valid = v;
        op       = o;
        in0      = a;
        in1      = b;
        if (push) exp_q.push_back({eo, ec, ez, ev});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'b000; in0 = 4'b0000; in1 = 4'b0000;
        #3;
        check("reset_out", out, 4'b0000);
        check("reset_flags", {1'b0, out_valid, carry, zero}, 4'b0000);
        check("reset_ovf", {3'b000, ovf}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //   v     op      in0      in1     push  out                     c     z     v
        issue(1'b1, 3'b000, 4'b0111, 4'b0010, 1'b1, SAT ? 4'b0111 : 4'b1001, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 3'b001, 4'b0011, 4'b0101, 1'b1, 4'b1110,                 1'b1, 1'b0, 1'b0);
        issue(1'b1, 3'b010, 4'b1100, 4'b0011, 1'b1, 4'b0000,                 1'b0, 1'b1, 1'b0);
        issue(1'b1, 3'b011, 4'b1100, 4'b0011, 1'b1, 4'b1111,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b100, 4'b1010, 4'b0110, 1'b1, 4'b1100,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b000, 4'b1111, 4'b0001, 1'b1, 4'b0000,                 1'b1, 1'b1, 1'b0);
        issue(1'b1, 3'b001, 4'b0101, 4'b0011, 1'b1, 4'b0010,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b001, 4'b1000, 4'b0001, 1'b1, SAT ? 4'b1000 : 4'b0111, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 3'b110, 4'b1111, 4'b1111, 1'b1, 4'b0000,                 1'b0, 1'b1, 1'b0);
        issue(1'b1, 3'b101, 4'b0011, 4'b0000, 1'b1, 4'b0011,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b101, 4'b0100, 4'b0000, 1'b1, 4'b0111,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b101, 4'b0101, 4'b0000, 1'b1, SAT ? 4'b0111 : 4'b1100, 1'b0, 1'b0, 1'b1);
        // Valid pattern 1,0,1: out must hold through the bubble.
        issue(1'b1, 3'b000, 4'b0001, 4'b0001, 1'b1, 4'b0010,                 1'b0, 1'b0, 1'b0);
        issue(1'b0, 3'b000, 4'b1111, 4'b1111, 1'b0, 4'b0000,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b111, 4'b1010, 4'b0000, 1'b1, 4'b1010,                 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bubble_valid", {3'b000, out_valid}, 4'b0000);
        check("bubble_hold", out, 4'b0010);

        // Asynchronous reset with two ops in flight (one in stage 1, one on the inputs).
        issue(1'b1, 3'b111, 4'b0101, 4'b0000, 1'b1, 4'b0101,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b100, 4'b1111, 4'b0000, 1'b0, 4'b0000,                 1'b0, 1'b0, 1'b0);
        issue(1'b1, 3'b000, 4'b0011, 4'b0011, 1'b0, 4'b0000,                 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_out", out, 4'b0000);
        check("async_rst_flags", {out_valid, carry, zero, ovf}, 4'b0000);
        check("async_rst_acc", dut.acc_r, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        issue(1'b1, 3'b101, 4'b0001, 4'b0000, 1'b1, 4'b0001,                 1'b0, 1'b0, 1'b0);
        issue(1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 4'b0000,                 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("pending_results", 4'(exp_q.size()), 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe_reg.md
# alu_pipe_reg

Parametrised, two-stage pipelined ALU with a run-time opcode, valid handshake, status flags and an internal accumulator. It supersedes the fixed-opcode registered ALU: the opcode now arrives per operation, and results carry a valid qualifier and flags. It sits between operand sources and result consumers in the datapath, one operation per clock, with no back-pressure.

## Interface
- N, default 4: operand/result width in bits (N ≥ 2).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands/opcode on this cycle are valid.
- op  in  3  opcode (encoding below).
- in0  in  N  operand A.
- in1  in  N  operand B.
- out  out  N  registered result.
- out_valid  out  1  out/flags updated this cycle.
- carry  out  1  carry (ADD/ACC) or borrow (SUB).
- zero  out  1  out == 0.
- ovf  out  1  signed two's-complement overflow.

## Operation
- Opcodes:
  - 000 ADD: in0+in1.
  - 001 SUB: in0−in1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 ACC: acc+in0; acc takes the result.
  - 110 CLR: result 0; acc ← 0.
  - 111 PASS: in0.
- Stage 1 captures in0, in1, op and in_valid every cycle, unconditionally.
- Stage 2 computes from the stage-1 registers.
  - If the stage-1 valid is high: out, flags and acc (ACC/CLR only) update, and out_valid=1.
  - Else out_valid=0, and out, flags and acc hold.
- Arithmetic is computed at N+1 bits.
  - carry = bit N for ADD/ACC.
  - carry = 1 for SUB when in0 < in1 (unsigned).
  - ovf set when the operands have the same sign (ADD/ACC) or differing signs (SUB) and the result sign differs from operand A.
  - Logic ops, PASS and CLR force carry=0 and ovf=0.
- zero reflects the final (post-saturation) out.
- Back-to-back ACC ops chain: each uses the acc value written by the preceding ACC/CLR, with no hazard.

## Timing
- Latency is exactly 2 cycles: inputs sampled at edge k appear on out/out_valid after edge k+1.
- Throughput is 1 op/cycle. in_valid may toggle freely; bubbles propagate as out_valid=0.
- Reset (asynchronous, immediate) sets all of the following to 0:
  - stage-1 registers;
  - out, out_valid, carry, zero, ovf;
  - acc.
- zero is 0 in reset even though out=0; it becomes meaningful only after the first valid result.
- Reset mid-stream discards both in-flight ops. The first op sampled after deassertion emerges 2 cycles later.
- No illegal opcodes exist; all 8 encodings are defined.

## Configuration
- `ALU_SAT_EN` defined: ADD, SUB and ACC saturate on ovf.
  - Positive overflow gives 0111…1; negative overflow gives 1000…0.
  - acc stores the saturated value.
  - ovf and carry still report the unsaturated condition.
- Undefined: results wrap modulo 2^N.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams OP_ADD … OP_PASS;
  - a 3-bit opcode typedef.
- Sub-module `alu_core` is purely combinational.
  - Inputs: a, b, op, acc.
  - Outputs: result, carry, ovf, acc_we.
  - It contains the saturation logic under `ALU_SAT_EN`.
- The top level holds the pipeline registers, acc, and the zero computation.

## Test plan (N=4)
- ADD 0111+0010, in_valid pulse → 2 cycles later:
  - wrap build: out=1001, ovf=1, carry=0;
  - `ALU_SAT_EN` build: out=0111.
- SUB 0011−0101 → out=1110, carry=1, ovf=0, zero=0. AND 1100&0011 → out=0000, zero=1, carry=0.
- CLR, then ACC in0=3, 4, 5 on consecutive cycles → out=0011, 0111, then:
  - wrap build: 1100 with ovf=1;
  - sat build: 0111 with ovf=1.
- Valid pattern 1,0,1 with ADD 1+1 and PASS 1010 → out_valid=1,0,1. out holds 0010 during the bubble, then shows 1010.
- Assert rst asynchronously between edges with two ops in flight:
  - out, flags, out_valid and acc go to 0 immediately;
  - the in-flight ops never appear;
  - after release, ACC in0=1 yields out=0001.
